// File: rtl/nano_pkg.sv
// Shared definitions for the 4-bit nano processor control path:
// width constants, opcode values, FSM state encoding and a small
// decode helper used by the instruction decode controller.
package nano_pkg;

  localparam int PC_W      = 3;
  localparam int DATA_W    = 4;
  localparam int INSTR_W   = 12;
  localparam int REG_SEL_W = 3;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_NEG  = 2'b01;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_JZR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  // R0 reads as constant zero, so any write aimed at it is dropped.
  function automatic logic writes_reg(input logic [1:0] op,
                                      input logic [REG_SEL_W-1:0] ra);
    return (op != OP_JZR) && (ra != '0);
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter for the nano processor: a small register that either
// loads a jump target or increments with natural wrap-around (7 -> 0).
// Load takes priority over Inc.
module program_counter
  import nano_pkg::*;
#(
  parameter int W = PC_W
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Inc,
  input  logic         Load,
  input  logic [W-1:0] Load_Val,
  output logic [W-1:0] Pc
);

  logic [W-1:0] pc_reg;
  logic [W-1:0] pc_next;

  // Select jump target, incremented address or hold.
  always_comb begin
    pc_next = pc_reg;
    if (Load) begin
      pc_next = Load_Val;
    end else if (Inc) begin
      pc_next = pc_reg + 1'b1;
    end
  end

  // Address register, cleared to the first ROM word on reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_reg <= '0;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign Pc = pc_reg;

endmodule

// File: rtl/instr_decode_ctrl.sv
// Instruction fetch/decode/sequencing stage of the 4-bit nano processor.
// Each instruction takes three cycles: FETCH latches the ROM word into the
// instruction register, EXEC presents the decoded operand/ALU controls, and
// WB holds those controls, pulses the bank write strobe and updates the PC.
// All controls are decoded from state and IR, so an asynchronous reset
// removes them (including Wr_Strobe) immediately.
//
// Optional build macro INSTR_DECODE_SINGLE_STEP_EN adds a Step input: a
// rising edge of Step starts one instruction from IDLE even when Run=0.
module instr_decode_ctrl
  import nano_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Run,
`ifdef INSTR_DECODE_SINGLE_STEP_EN
  input  logic                 Step,
`endif
  input  logic [INSTR_W-1:0]   Instr,
  input  logic                 Rs_Zero,
  output logic [PC_W-1:0]      Pc,
  output logic [REG_SEL_W-1:0] Mux_A_Sel,
  output logic [REG_SEL_W-1:0] Mux_B_Sel,
  output logic                 Neg_Sel,
  output logic                 Load_Sel,
  output logic [DATA_W-1:0]    Imm_Val,
  output logic [REG_SEL_W-1:0] Reg_En,
  output logic                 Wr_Strobe,
  output logic                 Busy
);

  state_t               state_reg;
  state_t               state_next;
  logic [INSTR_W-1:0]   ir_reg;
  logic [INSTR_W-1:0]   ir_next;
  logic                 pc_inc;
  logic                 pc_load;
  logic                 start_req;
  logic                 ctrl_active;

  // Instruction fields
  logic [1:0]           op;
  logic [REG_SEL_W-1:0] ra;
  logic [REG_SEL_W-1:0] rb;
  logic [DATA_W-1:0]    imm;
  logic [PC_W-1:0]      jmp_target;

  assign op         = ir_reg[11:10];
  assign ra         = ir_reg[9:7];
  assign rb         = ir_reg[6:4];
  assign imm        = ir_reg[3:0];
  assign jmp_target = ir_reg[2:0];

`ifdef INSTR_DECODE_SINGLE_STEP_EN
  logic step_prev_reg;

  // Remember last Step level so a single rising edge can be detected.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      step_prev_reg <= 1'b0;
    end else begin
      step_prev_reg <= Step;
    end
  end

  assign start_req = Run | (Step & ~step_prev_reg);
`else
  assign start_req = Run;
`endif

  // State and instruction register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= ST_IDLE;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ir_reg    <= ir_next;
    end
  end

  // Next-state sequencing, IR capture, PC control and decoded outputs.
  always_comb begin
    state_next  = state_reg;
    ir_next     = ir_reg;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    ctrl_active = 1'b0;
    Mux_A_Sel   = '0;
    Mux_B_Sel   = '0;
    Neg_Sel     = 1'b0;
    Load_Sel    = 1'b0;
    Imm_Val     = '0;
    Reg_En      = '0;
    Wr_Strobe   = 1'b0;
    Busy        = (state_reg != ST_IDLE);

    case (state_reg)
      ST_IDLE: begin
        if (start_req) begin
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ir_next    = Instr;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        ctrl_active = 1'b1;
        state_next  = ST_WB;
      end
      ST_WB: begin
        ctrl_active = 1'b1;
        Wr_Strobe   = writes_reg(op, ra);
        // Rs_Zero reflects the register selected by Mux_A_Sel (= RA) now.
        if ((op == OP_JZR) && Rs_Zero) begin
          pc_load = 1'b1;
        end else begin
          pc_inc = 1'b1;
        end
        state_next = Run ? ST_FETCH : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Controls are identical in EXEC and WB so the bank sees stable selects.
    if (ctrl_active) begin
      Mux_A_Sel = ra;
      Mux_B_Sel = (op == OP_ADD) ? rb : '0;
      Neg_Sel   = (op == OP_NEG);
      Load_Sel  = (op == OP_MOVI);
      Imm_Val   = imm;
      Reg_En    = (op == OP_JZR) ? '0 : ra;
    end
  end

  program_counter #(
    .W (PC_W)
  ) u_program_counter (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Inc      (pc_inc),
    .Load     (pc_load),
    .Load_Val (jmp_target),
    .Pc       (Pc)
  );

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Bench for instr_decode_ctrl. Surrounds the controller with a program ROM
// and an 8x4 register bank driven by its controls. Stimulus runs an
// ISA-level reference of the program and pushes one expected record per
// instruction; a monitor pops a record at every WB cycle and compares.
module tb_instr_decode_ctrl;
  import nano_pkg::*;

  logic                 Clk = 1'b0;
  logic                 Reset_n = 1'b0;
  logic                 Run = 1'b0;
  logic                 Step = 1'b0;
  logic [INSTR_W-1:0]   Instr;
  logic                 Rs_Zero;
  logic [PC_W-1:0]      Pc;
  logic [REG_SEL_W-1:0] Mux_A_Sel;
  logic [REG_SEL_W-1:0] Mux_B_Sel;
  logic                 Neg_Sel;
  logic                 Load_Sel;
  logic [DATA_W-1:0]    Imm_Val;
  logic [REG_SEL_W-1:0] Reg_En;
  logic                 Wr_Strobe;
  logic                 Busy;

  instr_decode_ctrl dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Run       (Run),
`ifdef INSTR_DECODE_SINGLE_STEP_EN
    .Step      (Step),
`endif
    .Instr     (Instr),
    .Rs_Zero   (Rs_Zero),
    .Pc        (Pc),
    .Mux_A_Sel (Mux_A_Sel),
    .Mux_B_Sel (Mux_B_Sel),
    .Neg_Sel   (Neg_Sel),
    .Load_Sel  (Load_Sel),
    .Imm_Val   (Imm_Val),
    .Reg_En    (Reg_En),
    .Wr_Strobe (Wr_Strobe),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  // Environment: combinational ROM and register bank fed by DUT controls
  logic [11:0] rom [8];
  logic [3:0]  bank [8];

  assign Instr   = rom[Pc];
  assign Rs_Zero = (bank[Mux_A_Sel] == 4'd0);

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 8; i++) bank[i] <= 4'd0;
    end else if (Wr_Strobe) begin
      bank[Reg_En] <= Load_Sel ? Imm_Val :
                      Neg_Sel  ? 4'd0 - bank[Mux_A_Sel] :
                                 bank[Mux_A_Sel] + bank[Mux_B_Sel];
    end
  end

  // Scoreboard
  typedef struct {
    logic [2:0] pc;
    logic [2:0] a;
    logic [2:0] b;
    logic       neg;
    logic       load;
    logic [3:0] imm;
    logic [2:0] reg_en;
    logic       wr;
    logic [2:0] next_pc;
  } exp_t;

  exp_t sb_q[$];
  int   chk_cnt = 0;
  int   err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // ISA-level reference state
  logic [3:0] mregs [8];
  logic [2:0] mpc;

  // Execute n instructions at ISA level, queueing what the controller must show.
  task automatic model_run(input int n);
    exp_t       e;
    logic [11:0] w;
    logic [1:0]  opc;
    logic [2:0]  r_a, r_b;
    for (int k = 0; k < n; k++) begin
      w   = rom[mpc];
      opc = w[11:10];
      r_a = w[9:7];
      r_b = w[6:4];
      e.pc     = mpc;
      e.a      = r_a;
      e.b      = (opc == 2'b00) ? r_b : 3'd0;
      e.neg    = (opc == 2'b01);
      e.load   = (opc == 2'b10);
      e.imm    = w[3:0];
      e.reg_en = (opc == 2'b11) ? 3'd0 : r_a;
      e.wr     = (opc != 2'b11) && (r_a != 3'd0);
      if (opc == 2'b11 && mregs[r_a] == 4'd0) e.next_pc = w[2:0];
      else                                    e.next_pc = mpc + 3'd1;
      if (e.wr) begin
        case (opc)
          2'b00:   mregs[r_a] = mregs[r_a] + mregs[r_b];
          2'b01:   mregs[r_a] = 4'd0 - mregs[r_a];
          default: mregs[r_a] = w[3:0];
        endcase
      end
      mpc = e.next_pc;
      sb_q.push_back(e);
    end
  endtask

  // Monitor: follows FETCH/EXEC/WB by counting busy cycles
  initial begin
    int         phase;
    logic       pend;
    logic [2:0] pend_pc;
    exp_t       e;
    logic [2:0] xa, xb, xr;
    logic       xn, xl;
    logic [3:0] xi;
    phase = 0;
    pend  = 1'b0;
    pend_pc = 3'd0;
    forever begin
      @(negedge Clk);
      if (!Reset_n) begin
        phase = 0;
        pend  = 1'b0;
        continue;
      end
      if (pend) begin
        check("next_pc", Pc, pend_pc);
        pend = 1'b0;
      end
      if (!Busy) begin
        phase = 0;
        check("idle_outputs", {Mux_A_Sel, Mux_B_Sel, Neg_Sel, Load_Sel, Imm_Val, Reg_En, Wr_Strobe}, 0);
        continue;
      end
      phase = (phase == 3) ? 1 : phase + 1;
      if (phase == 1) begin
        check("fetch_strobe", Wr_Strobe, 0);
      end else if (phase == 2) begin
        check("exec_strobe", Wr_Strobe, 0);
        xa = Mux_A_Sel; xb = Mux_B_Sel; xn = Neg_Sel;
        xl = Load_Sel;  xi = Imm_Val;   xr = Reg_En;
      end else begin
        if (sb_q.size() == 0) begin
          check("unexpected_instr_pc", Pc, 8);
        end else begin
          e = sb_q.pop_front();
          $display("instr pc=%0d a=%0d b=%0d neg=%0b load=%0b imm=%0d reg_en=%0d wr=%0b",
                   Pc, Mux_A_Sel, Mux_B_Sel, Neg_Sel, Load_Sel, Imm_Val, Reg_En, Wr_Strobe);
          check("wb_pc",        Pc,        e.pc);
          check("wb_mux_a",     Mux_A_Sel, e.a);
          check("wb_mux_b",     Mux_B_Sel, e.b);
          check("wb_neg",       Neg_Sel,   e.neg);
          check("wb_load",      Load_Sel,  e.load);
          check("wb_imm",       Imm_Val,   e.imm);
          check("wb_reg_en",    Reg_En,    e.reg_en);
          check("wb_strobe",    Wr_Strobe, e.wr);
          check("exec_mux_a",   xa, e.a);
          check("exec_mux_b",   xb, e.b);
          check("exec_neg",     xn, e.neg);
          check("exec_load",    xl, e.load);
          check("exec_imm",     xi, e.imm);
          check("exec_reg_en",  xr, e.reg_en);
          pend    = 1'b1;
          pend_pc = e.next_pc;
        end
      end
    end
  end

  task automatic do_reset();
    Run = 1'b0;
    Reset_n = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 8; i++) mregs[i] = 4'd0;
    mpc = 3'd0;
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  task automatic compare_bank();
    for (int i = 0; i < 8; i++) check("bank_reg", bank[i], mregs[i]);
  endtask

  // Run n instructions from IDLE, dropping Run in FETCH/EXEC/WB of the last one.
  task automatic run_burst(input int n, input int drop);
    logic done;
    model_run(n);
    @(posedge Clk);
    #1 Run = 1'b1;
    repeat (3 * n - 2 + drop) @(posedge Clk);
    #1 Run = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge Clk);
      #2;
      if (sb_q.size() == 0 && !Busy) begin
        done = 1'b1;
        break;
      end
    end
    check("burst_done", done, 1);
    if (!done) begin
      do_reset();
    end else begin
      check("idle_busy", Busy, 0);
      compare_bank();
    end
  endtask

  task automatic load_prog_a();
    rom[0] = 12'b10_001_000_0111; // MOVI R1,7
    rom[1] = 12'b00_010_001_0000; // ADD  R2,R1
    rom[2] = 12'b11_001_0000_110; // JZR  R1,6
    rom[3] = 12'b01_011_000_0000; // NEG  R3
    rom[4] = 12'b10_100_000_1001; // MOVI R4,9
    rom[5] = 12'b00_100_010_0000; // ADD  R4,R2
    rom[6] = 12'b01_100_000_0000; // NEG  R4
    rom[7] = 12'b10_000_000_0101; // MOVI R0,5
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom[i] = 12'd0;

    // Reset state
    do_reset();
    Reset_n = 1'b0;
    @(posedge Clk);
    #1;
    check("rst_pc", Pc, 0);
    check("rst_busy", Busy, 0);
    check("rst_strobe", Wr_Strobe, 0);
    check("rst_ctrl", {Mux_A_Sel, Mux_B_Sel, Neg_Sel, Load_Sel, Imm_Val, Reg_En}, 0);
    Reset_n = 1'b1;
    repeat (3) @(posedge Clk);
    #1 check("idle_no_run_busy", Busy, 0);

    // Reset during EXEC of the instruction at Pc=5
    load_prog_a();
    model_run(5);
    @(posedge Clk);
    #1 Run = 1'b1;
    repeat (17) @(posedge Clk);
    #1;
    check("pre_rst_pc", Pc, 5);
    check("pre_rst_reg_en", Reg_En, 4);
    #1 Reset_n = 1'b0;
    #1;
    check("midrst_pc", Pc, 0);
    check("midrst_strobe", Wr_Strobe, 0);
    check("midrst_busy", Busy, 0);
    check("midrst_ctrl", {Mux_A_Sel, Mux_B_Sel, Neg_Sel, Load_Sel, Imm_Val, Reg_En}, 0);
    check("midrst_sb_empty", sb_q.size(), 0);
    Run = 1'b0;
    do_reset();
    #1 check("post_rst_busy", Busy, 0);

    // Full program with wrap, Run dropped in EXEC, then resume at next Pc
    run_burst(9, 1);
    run_burst(3, 2);

    // Taken JZR at Pc=2 and a self-looping JZR
    do_reset();
    for (int i = 0; i < 8; i++) rom[i] = 12'd0;
    rom[0] = 12'b10_110_000_0001; // MOVI R6,1
    rom[1] = 12'b01_001_000_0000; // NEG  R1
    rom[2] = 12'b11_001_0000_110; // JZR  R1,6
    rom[6] = 12'b11_000_0000_110; // JZR  R0,6
    run_burst(6, 0);

    // Randomised programs and Run-drop points
    do_reset();
    for (int i = 0; i < 8; i++) rom[i] = 12'($urandom);
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        rom[$urandom_range(0, 7)] = 12'($urandom);
      end
      run_burst(int'($urandom_range(1, 5)), int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 3)) @(posedge Clk);
    end

    repeat (2) @(posedge Clk);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
